// File: rtl/e1_frame_sync_sipo.sv
// E1 serial-to-byte converter with G.706 FAS/NFAS frame alignment.
// Define E1FS_STATS_EN to add the fas_err_total / sync_loss_cnt counters.
module e1_frame_sync_sipo #(
  parameter logic [6:0] FAS_PATTERN     = 7'b0011011,
  parameter int         MAX_FAS_ERR     = 3,
  parameter bit         OUT_BEFORE_SYNC = 1'b0
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        din,
  input  logic        din_valid,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic [4:0]  ts_index,
  output logic        frame_sync,
  output logic        fas_frame,
  output logic        sync_loss
`ifdef E1FS_STATS_EN
  ,
  output logic [15:0] fas_err_total,
  output logic [7:0]  sync_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH,
    CHK_NFAS,
    CHK_FAS,
    SYNC
  } state_t;

  localparam logic [2:0] ERR_LIM = 3'(MAX_FAS_ERR);

  state_t     state, state_nx;
  logic [7:0] sr, sr_nx;
  logic [7:0] bitpos, bitpos_nx;
  logic       parity, parity_nx;
  logic [2:0] err_cnt, err_nx;
  logic       ts0_end, fas_ok;
  logic       fas_err, loss, emit;

  always_comb begin
    sr_nx     = {sr[6:0], din};
    ts0_end   = (bitpos == 8'd7);
    fas_ok    = (sr_nx[6:0] == FAS_PATTERN);
    state_nx  = state;
    err_nx    = err_cnt;
    bitpos_nx = bitpos + 8'd1;
    parity_nx = parity ^ (bitpos == 8'hFF);
    fas_err   = 1'b0;
    loss      = 1'b0;
    unique case (state)
      SEARCH: begin
        bitpos_nx = bitpos;
        parity_nx = parity;
        // a match means the word just completed was TS0 of a FAS frame
        if (fas_ok) begin
          bitpos_nx = 8'd8;
          parity_nx = 1'b1;
          state_nx  = CHK_NFAS;
        end
      end
      CHK_NFAS: begin
        if (ts0_end && !parity)
          state_nx = sr_nx[6] ? CHK_FAS : SEARCH;
      end
      CHK_FAS: begin
        if (ts0_end && parity) begin
          state_nx = fas_ok ? SYNC : SEARCH;
          err_nx   = '0;
        end
      end
      SYNC: begin
        if (ts0_end && parity) begin
          if (fas_ok) begin
            err_nx = '0;
          end else begin
            fas_err = 1'b1;
            if (err_cnt + 3'd1 >= ERR_LIM) begin
              state_nx = SEARCH;
              loss     = 1'b1;
              err_nx   = '0;
            end else begin
              err_nx = err_cnt + 3'd1;
            end
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
    // the confirming TS0 is output; the byte that drops sync is not
    emit = din_valid && (bitpos[2:0] == 3'd7) &&
           ((state_nx == SYNC) || OUT_BEFORE_SYNC);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= SEARCH;
      sr         <= '0;
      bitpos     <= '0;
      parity     <= 1'b0;
      err_cnt    <= '0;
      dout       <= '0;
      ts_index   <= '0;
      dout_valid <= 1'b0;
      fas_frame  <= 1'b0;
      sync_loss  <= 1'b0;
    end else begin
      dout_valid <= emit;
      sync_loss  <= din_valid && loss;
      if (din_valid) begin
        state   <= state_nx;
        sr      <= sr_nx;
        bitpos  <= bitpos_nx;
        parity  <= parity_nx;
        err_cnt <= err_nx;
      end
      if (emit) begin
        dout      <= sr_nx;
        ts_index  <= bitpos[7:3];
        fas_frame <= parity;
      end
    end
  end

  assign frame_sync = (state == SYNC);

`ifdef E1FS_STATS_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      fas_err_total <= '0;
      sync_loss_cnt <= '0;
    end else begin
      if (din_valid && fas_err && fas_err_total != 16'hFFFF)
        fas_err_total <= fas_err_total + 16'd1;
      if (din_valid && loss && sync_loss_cnt != 8'hFF)
        sync_loss_cnt <= sync_loss_cnt + 8'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = fas_err;
`endif

endmodule

// File: tb/tb_e1_frame_sync_sipo.sv
// Directed E1 alignment scenarios; output bytes checked against a queue.
// Define E1FS_STATS_EN to run the stats-counter scenario instead of loss.
`timescale 1ns/1ps
module tb_e1_frame_sync_sipo;

`ifdef E1FS_STATS_EN
  localparam int MAXE = 7;
`else
  localparam int MAXE = 3;
`endif

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic [7:0] dout;
  logic dout_valid;
  logic [4:0] ts_index;
  logic frame_sync, fas_frame, sync_loss;
`ifdef E1FS_STATS_EN
  logic [15:0] fas_err_total;
  logic [7:0] sync_loss_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int loss_seen = 0;
  int gap = 4;
  logic [13:0] sb[$];

  always #5 clk = ~clk;

  e1_frame_sync_sipo #(
    .FAS_PATTERN(7'b0011011),
    .MAX_FAS_ERR(MAXE),
    .OUT_BEFORE_SYNC(1'b0)
  ) dut (
    .clk(clk),
    .clear(clear),
    .din(din),
    .din_valid(din_valid),
    .dout(dout),
    .dout_valid(dout_valid),
    .ts_index(ts_index),
    .frame_sync(frame_sync),
    .fas_frame(fas_frame),
    .sync_loss(sync_loss)
`ifdef E1FS_STATS_EN
    ,
    .fas_err_total(fas_err_total),
    .sync_loss_cnt(sync_loss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sync_loss === 1'b1) loss_seen++;
    if (dout_valid === 1'b1) begin
      check("out_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        check("out_byte_ts_fas", {dout, ts_index, fas_frame}, sb.pop_front());
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    if (gap > 1) begin
      @(negedge clk);
      din_valid = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [4:0] ts,
                           input logic fas, input bit emit);
    if (emit) sb.push_back({b, ts, fas});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_ts(input logic fas, input bit bad, input bit emit,
                         input int lo, input int hi);
    logic [7:0] b;
    for (int t = lo; t <= hi; t++) begin
      if (t == 0) b = bad ? 8'h00 : (fas ? 8'h1B : 8'h40);
      else b = 8'(t);
      send_byte(b, 5'(t), fas, emit);
    end
  endtask

  task automatic send_frame(input logic fas, input bit bad, input bit emit);
    send_ts(fas, bad, emit, 0, 31);
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drained(input string tag);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_ts"}, ts_index, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_fsync"}, frame_sync, 0);
    check({tag, "_fas"}, fas_frame, 0);
    check({tag, "_loss"}, sync_loss, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    outputs_zero("reset");
    clear = 1'b0;

    // aligned stream, one strobe every 4 clocks
    gap = 4;
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    idle();
    check("aligned_fs_before", frame_sync, 0);
    send_ts(1'b1, 1'b0, 1'b1, 0, 0);
    idle();
    check("aligned_fs_rise", frame_sync, 1);
    send_ts(1'b1, 1'b0, 1'b1, 1, 31);
    for (int f = 3; f <= 7; f++) send_frame(f % 2 == 0, 1'b0, 1'b1);
    idle();
    idle();
    drained("aligned_drained");

    // five garbage bits ahead of the stream, back-to-back strobes
    do_clear();
    gap = 1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    idle();
    check("offset_fs_before", frame_sync, 0);
    send_ts(1'b1, 1'b0, 1'b1, 0, 0);
    idle();
    check("offset_fs_rise", frame_sync, 1);
    send_ts(1'b1, 1'b0, 1'b1, 1, 31);
    send_frame(1'b0, 1'b0, 1'b1);
    idle();
    idle();
    drained("offset_drained");

    // false FAS in TS5, rejected by NFAS bit 2 = 0 one frame later
    do_clear();
    send_ts(1'b1, 1'b1, 1'b0, 0, 4);
    send_byte(8'h1B, 5'd5, 1'b0, 1'b0);
    for (int t = 6; t < 64; t++) send_byte(8'h00, 5'(t), 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    idle();
    check("false_fs_before", frame_sync, 0);
    send_ts(1'b1, 1'b0, 1'b1, 0, 0);
    idle();
    check("false_fs_rise", frame_sync, 1);
    send_ts(1'b1, 1'b0, 1'b1, 1, 31);
    send_frame(1'b0, 1'b0, 1'b1);
    idle();
    idle();
    drained("false_drained");

`ifdef E1FS_STATS_EN
    // five errored FAS words with a limit of seven
    do_clear();
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b1);
    for (int f = 3; f <= 13; f++)
      send_frame(f % 2 == 0, (f % 2 == 0) && f <= 12, 1'b1);
    idle();
    check("stats_err_total", fas_err_total, 5);
    check("stats_loss_cnt", sync_loss_cnt, 0);
    check("stats_fs_held", frame_sync, 1);
    idle();
    drained("stats_drained");
`else
    // two errors, a good FAS, then three errors in a row
    do_clear();
    loss_seen = 0;
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b1);
    for (int f = 3; f <= 13; f++)
      send_frame(f % 2 == 0,
                 f == 4 || f == 6 || f == 10 || f == 12, 1'b1);
    idle();
    check("loss_none_yet", loss_seen, 0);
    check("loss_fs_held", frame_sync, 1);
    send_ts(1'b1, 1'b1, 1'b0, 0, 0);
    idle();
    check("loss_pulse", sync_loss, 1);
    check("loss_fs_drop", frame_sync, 0);
    idle();
    check("loss_pulse_end", sync_loss, 0);
    check("loss_once", loss_seen, 1);
    drained("loss_drained");
`endif

    // clear mid-frame while in sync, then full resync
    do_clear();
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b1);
    send_ts(1'b0, 1'b0, 1'b1, 0, 10);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    clear = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    outputs_zero("midclear");
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    idle();
    check("resync_fs_before", frame_sync, 0);
    send_ts(1'b1, 1'b0, 1'b1, 0, 0);
    idle();
    check("resync_fs_rise", frame_sync, 1);
    idle();
    drained("resync_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e1_frame_sync_sipo.md
Name: e1_frame_sync_sipo

Overview:
- Upstream stage of the E1 demultiplexer. Converts the received 2.048 Mbit/s serial stream into bytes and finds G.706 frame alignment: FAS in TS0 of even frames, NFAS in TS0 of odd frames.
- Outputs each byte with its timeslot index (0..31) and a frame-sync flag. The downstream timeslot counter/demux starts on TS0 of the first aligned frame.

Parameters:
- FAS_PATTERN, 7'b0011011, bits 2..8 of TS0 in FAS frames (MSB = bit 2).
- MAX_FAS_ERR, 3, consecutive errored FAS words that cause loss of sync (range 1..7).
- OUT_BEFORE_SYNC, 0, 1 = emit dout_valid while not in sync; 0 = suppress it.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clear  input  1  synchronous active-high reset.
- din  input  1  serial data bit, MSB of each timeslot first.
- din_valid  input  1  one-cycle strobe; din is sampled only when high.
- dout  output  8  completed byte; first-received bit in dout[7].
- dout_valid  output  1  one-cycle pulse when dout/ts_index are new.
- ts_index  output  5  timeslot of dout, 0..31.
- frame_sync  output  1  high while state = SYNC.
- fas_frame  output  1  high when dout belongs to a FAS (even) frame.
- sync_loss  output  1  one-cycle pulse on the SYNC -> SEARCH transition.

Behaviour:
- Reset (clear = 1 at a clock edge):
  - state = SEARCH; shift register 8'h00; bitpos = 0; err_cnt = 0.
  - Outputs: dout = 8'h00, ts_index = 0, dout_valid = 0, frame_sync = 0, fas_frame = 0, sync_loss = 0.
  - clear takes priority over din_valid on the same edge. Asserting clear mid-frame discards all alignment.
- Shift: on every din_valid, sr <= {sr[6:0], din}. No action without din_valid.
- Bit position: bitpos (0..255) is the index of the next expected bit in the frame.
  - Advances on every din_valid except in SEARCH.
  - Wraps 255 -> 0; frame parity toggles on the wrap.
  - Byte boundary = the din_valid that fills bitpos[2:0] = 7. The value checked is the new sr = {sr[6:0], din}.
- States:
  - SEARCH:
    - On each din_valid, compare the 7 LSBs of the new sr with FAS_PATTERN.
    - Match: bitpos <= 8, parity <= FAS, go to CHK_NFAS.
    - No match: stay. Search is bit-by-bit sliding.
  - CHK_NFAS:
    - At the next TS0 byte boundary (bitpos = 7, NFAS frame), test the new sr[6], which is bit 2.
    - Bit 2 = 1: go to CHK_FAS. Bit 2 = 0: go to SEARCH.
  - CHK_FAS:
    - At the next TS0 boundary (FAS frame), new sr[6:0] == FAS_PATTERN: go to SYNC with err_cnt = 0. Otherwise go to SEARCH.
  - SYNC:
    - At each FAS-frame TS0 boundary: match -> err_cnt = 0; mismatch -> err_cnt + 1.
    - When err_cnt would reach MAX_FAS_ERR: go to SEARCH, pulse sync_loss for one cycle, frame_sync = 0 in the same cycle.
    - NFAS bit 2 is not checked in SYNC.
- Output timing:
  - At each byte boundary (in SYNC, or in any state when OUT_BEFORE_SYNC = 1), the cycle after the completing din_valid:
    - dout = completed byte, ts_index = bitpos[7:3] of that byte, fas_frame = parity, dout_valid = 1 for exactly one cycle.
  - Latency from the strobe of the last bit to dout_valid = 1 clock.
  - In SEARCH, ts_index is undefined-but-stable and dout_valid follows OUT_BEFORE_SYNC.
- On entry to SYNC, the confirming TS0 byte is itself output with ts_index = 0, fas_frame = 1.
- Back-to-back din_valid on every clock is legal. There is no output backpressure.

Optional Feature:
- Macro E1FS_STATS_EN.
- Defined:
  - Adds output fas_err_total [15:0]: counts every errored FAS word detected in SYNC.
  - Saturates at 16'hFFFF. Cleared only by clear.
  - Adds output sync_loss_cnt [7:0]: counts sync_loss pulses, saturating at 8'hFF.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Aligned stream: 8 frames, TS0 alternating 8'h1B / 8'h40, TSn = n (FAS frame first), one din_valid every 4 clocks.
  - frame_sync rises on TS0 of frame 3 (2nd FAS).
  - From then on, dout sequence is 1B,01..1F,40,01..1F with ts_index 0..31, fas_frame alternating per frame.
- Offset: 5 garbage bits, then the same stream.
  - Sync is achieved at the same frame; the byte values above are unaffected.
- False FAS: the 8'h1B pattern appears inside TS5 and is followed by an NFAS check of bit 2 = 0.
  - Returns to SEARCH, then locks on the real FAS.
  - No dout_valid while unsynced (OUT_BEFORE_SYNC = 0).
- Loss: in SYNC, corrupt TS0 of 3 consecutive FAS frames to 8'h00.
  - sync_loss pulses once, one cycle after the 3rd errored TS0.
  - frame_sync = 0.
  - Two errors then one good FAS: no loss.
- clear asserted mid-frame while in SYNC.
  - All outputs 0 the next cycle; resync requires a full FAS / NFAS / FAS sequence.
- With E1FS_STATS_EN: 5 errored FAS words, MAX_FAS_ERR = 7.
  - fas_err_total = 5, sync_loss_cnt = 0.
